// File: rtl/i2c_slave_ctrl_if.sv
// Pin-side and register-file-side signals of the I2C slave controller.
// The slave modport is the controller; the master modport is the pad and register file around it.
interface i2c_slave_ctrl_if #(parameter int LENGTH = 7);
  logic              enable;
  logic [LENGTH-1:0] own_address;
  logic              scl;
  logic              sda_in;
  logic              sda_oe;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic [7:0]        tx_data;
  logic              tx_req;
  logic              addr_match;
  logic              rw;
  logic              busy;

  modport slave (
    input  enable, own_address, scl, sda_in, tx_data,
    output sda_oe, rx_data, rx_valid, tx_req, addr_match, rw, busy
  );

  modport master (
    output enable, own_address, scl, sda_in, tx_data,
    input  sda_oe, rx_data, rx_valid, tx_req, addr_match, rw, busy
  );
endinterface

// File: rtl/i2c_slave_ctrl.sv
// I2C slave control unit: oversampled SCL/SDA, START/STOP detection, address match,
// ACK generation and byte transfer in both directions.
module i2c_slave_ctrl #(
  parameter int LENGTH      = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  i2c_slave_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, WAIT_STOP
  } state_t;

  state_t            state;
  logic [SYNC_STAGES:0] scl_sh, sda_sh;
  logic [2:0]        cnt;
  logic [7:0]        rx_sh, tx_sh;
  logic              tx_load;

  // One extra flop beyond the synchronizer holds the previous value for edge detection.
  // Reset to 0 so a released bus after reset can only look like a harmless STOP, never a START.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sh <= '0;
      sda_sh <= '0;
    end else begin
      scl_sh <= {scl_sh[SYNC_STAGES-1:0], bus.scl};
      sda_sh <= {sda_sh[SYNC_STAGES-1:0], bus.sda_in};
    end
  end

  logic scl_cur, scl_old, sda_cur, sda_old;
  logic scl_rise, scl_fall, start_det, stop_det;
  logic [7:0]        byte_in;
  logic [LENGTH-1:0] addr_in;

  assign scl_cur   = scl_sh[SYNC_STAGES-1];
  assign scl_old   = scl_sh[SYNC_STAGES];
  assign sda_cur   = sda_sh[SYNC_STAGES-1];
  assign sda_old   = sda_sh[SYNC_STAGES];
  assign scl_rise  = scl_cur & ~scl_old;
  assign scl_fall  = ~scl_cur & scl_old;
  assign start_det = scl_cur & scl_old & sda_old & ~sda_cur;
  assign stop_det  = scl_cur & scl_old & ~sda_old & sda_cur;
  assign byte_in   = {rx_sh[6:0], sda_cur};
  assign addr_in   = byte_in[7 -: LENGTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      rx_sh          <= '0;
      tx_sh          <= '0;
      tx_load        <= 1'b0;
      bus.sda_oe     <= 1'b0;
      bus.rx_data    <= '0;
      bus.rx_valid   <= 1'b0;
      bus.tx_req     <= 1'b0;
      bus.addr_match <= 1'b0;
      bus.rw         <= 1'b0;
      bus.busy       <= 1'b0;
    end else begin
      bus.rx_valid <= 1'b0;
      bus.tx_req   <= 1'b0;
      if (stop_det) begin
        state          <= IDLE;
        cnt            <= '0;
        tx_load        <= 1'b0;
        bus.sda_oe     <= 1'b0;
        bus.addr_match <= 1'b0;
        bus.busy       <= 1'b0;
      end else if (start_det) begin
        state          <= ADDR;
        cnt            <= '0;
        tx_load        <= 1'b0;
        bus.sda_oe     <= 1'b0;
        bus.addr_match <= 1'b0;
        bus.busy       <= 1'b1;
      end else begin
        case (state)
          ADDR: if (scl_rise) begin
            rx_sh <= byte_in;
            cnt   <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              if (bus.enable && addr_in == bus.own_address) begin
                state          <= ADDR_ACK;
                bus.addr_match <= 1'b1;
                bus.rw         <= byte_in[0];
                bus.tx_req     <= byte_in[0];
              end else begin
                state <= WAIT_STOP;
              end
            end
          end
          // sda_oe doubles as the ACK phase: first fall pulls low, second fall ends the slot.
          ADDR_ACK, RX_ACK: if (scl_fall) begin
            if (!bus.sda_oe) begin
              bus.sda_oe <= 1'b1;
            end else if (state == ADDR_ACK && bus.rw) begin
              tx_sh      <= bus.tx_data;
              bus.sda_oe <= ~bus.tx_data[7];
              cnt        <= '0;
              state      <= TX;
            end else begin
              bus.sda_oe <= 1'b0;
              state      <= RX;
            end
          end
          RX: if (scl_rise) begin
            rx_sh <= byte_in;
            cnt   <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              bus.rx_data  <= byte_in;
              bus.rx_valid <= 1'b1;
              state        <= RX_ACK;
            end
          end
          TX: if (scl_fall) begin
            if (tx_load) begin
              tx_sh      <= bus.tx_data;
              bus.sda_oe <= ~bus.tx_data[7];
              cnt        <= '0;
              tx_load    <= 1'b0;
            end else if (cnt == 3'd7) begin
              bus.sda_oe <= 1'b0;
              cnt        <= '0;
              state      <= TX_ACK;
            end else begin
              tx_sh      <= {tx_sh[6:0], 1'b0};
              bus.sda_oe <= ~tx_sh[6];
              cnt        <= cnt + 3'd1;
            end
          end
          // Master ACK asks for another byte, loaded at the fall that ends this slot.
          TX_ACK: if (scl_rise) begin
            if (!sda_cur) begin
              bus.tx_req <= 1'b1;
              tx_load    <= 1'b1;
              state      <= TX;
            end else begin
              state <= WAIT_STOP;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Bench for i2c_slave_ctrl: bit-level I2C master, directed scenarios plus random
// transactions checked against a transaction-level expectation model.
module tb_i2c_slave_ctrl;
  localparam int         Q   = 25;       // quarter SCL period in clk cycles (100 kHz at 10 MHz)
  localparam logic [6:0] OWN = 7'h3A;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic m_sda = 1'b1;

  i2c_slave_ctrl_if #(.LENGTH(7)) bus();
  i2c_slave_ctrl #(.LENGTH(7), .SYNC_STAGES(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #50 clk = ~clk;
  assign bus.sda_in = m_sda & ~bus.sda_oe;

  int checks = 0, failures = 0;
  int n_rxv = 0, n_txr = 0;
  bit oe_seen = 0, oe_bad = 0;
  logic prev_oe = 1'b0;
  logic [7:0] fix_q[$], exp_tx[$];
  logic [7:0] wdat [4];

  always @(posedge clk) begin
    if (bus.rx_valid) n_rxv++;
    if (bus.tx_req)   n_txr++;
    if (bus.sda_oe)   oe_seen = 1;
  end

  // The slave may only move SDA while SCL is low
  always @(negedge clk) begin
    if (rst_n && bus.scl && bus.sda_oe !== prev_oe) oe_bad = 1;
    prev_oe = bus.sda_oe;
  end

  // Register-file stand-in: answers each TxReq with the next byte and records it
  initial begin : tx_resp
    logic [7:0] v;
    bus.tx_data = 8'h00;
    forever begin
      @(negedge clk);
      if (bus.tx_req) begin
        v = (fix_q.size() > 0) ? fix_q.pop_front() : 8'($urandom);
        bus.tx_data = v;
        exp_tx.push_back(v);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    if (!bus.scl) begin
      m_sda = 1'b1; tick(Q);
      bus.scl = 1'b1; tick(Q);
    end
    m_sda = 1'b0; tick(Q);
    bus.scl = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; tick(Q);
    bus.scl = 1'b1; tick(Q);
    m_sda = 1'b1; tick(2*Q);
  endtask

  task automatic bit_x(input logic b, output logic s);
    m_sda = b; tick(Q);
    bus.scl = 1'b1; tick(Q);
    s = bus.sda_in; tick(Q);
    bus.scl = 1'b0; tick(Q);
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic nak);
    logic s;
    for (int i = 7; i >= 0; i--) bit_x(d[i], s);
    bit_x(1'b1, nak);
  endtask

  task automatic rd_byte(input logic mnak, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_x(1'b1, s);
      d[i] = s;
    end
    bit_x(mnak, s);
  endtask

  // One transaction: expectations follow from address, Enable and direction alone
  task automatic run_txn(input string tag, input logic [7:0] a, input int nb, input bit do_stop);
    int rxv0, txr0;
    logic nak;
    logic [7:0] d;
    bit m;
    m = bus.enable && (a[7:1] == OWN);
    rxv0 = n_rxv; txr0 = n_txr;
    exp_tx.delete();
    oe_seen = 0;
    i2c_start();
    wr_byte(a, nak);
    chk({tag, "/addr_ack"}, nak, !m);
    chk({tag, "/match"}, bus.addr_match, m);
    chk({tag, "/busy"}, bus.busy, 1);
    if (m) chk({tag, "/rw"}, bus.rw, a[0]);
    for (int k = 0; k < nb; k++) begin
      if (!a[0]) begin
        wr_byte(wdat[k], nak);
        chk({tag, "/data_ack"}, nak, !m);
      end else begin
        rd_byte(k == nb - 1, d);
        if (m) begin
          chk({tag, "/txq_len"}, exp_tx.size() > 0, 1);
          if (exp_tx.size() > 0) chk({tag, "/rd_data"}, d, exp_tx.pop_front());
        end else begin
          chk({tag, "/rd_idle"}, d, 8'hFF);
        end
      end
    end
    chk({tag, "/rxv_cnt"}, n_rxv - rxv0, (m && !a[0]) ? nb : 0);
    chk({tag, "/txr_cnt"}, n_txr - txr0, (m && a[0]) ? nb : 0);
    if (m && !a[0]) chk({tag, "/rx_data"}, bus.rx_data, wdat[nb-1]);
    if (!m) chk({tag, "/no_oe"}, oe_seen, 0);
    if (do_stop) begin
      i2c_stop();
      chk({tag, "/busy_end"}, bus.busy, 0);
      chk({tag, "/match_end"}, bus.addr_match, 0);
    end
  endtask

  initial begin : main
    logic nak, s;
    int wait_n;
    bus.scl = 1'b1;
    bus.enable = 1'b1;
    bus.own_address = OWN;
    tick(5);
    chk("reset_outs", {bus.sda_oe, bus.rx_data, bus.rx_valid, bus.tx_req,
                       bus.addr_match, bus.rw, bus.busy}, 0);
    rst_n = 1'b1;
    tick(5);

    wdat[0] = 8'hA5; run_txn("write", 8'h74, 1, 1);
    wdat[0] = 8'h11; run_txn("mismatch", 8'h76, 1, 1);
    fix_q.push_back(8'h5A); fix_q.push_back(8'hC3);
    run_txn("read", 8'h75, 2, 1);

    wdat[0] = 8'h10; run_txn("rs_wr", 8'h74, 1, 0);
    run_txn("rs_rd", 8'h75, 1, 1);
    chk("rs/rx_data", bus.rx_data, 8'h10);

    // Reset while the slave holds the data ACK
    i2c_start();
    wr_byte(8'h74, nak);
    chk("rst/addr_ack", nak, 0);
    for (int i = 7; i >= 0; i--) bit_x(1'b0, s);
    m_sda = 1'b1;
    wait_n = 0;
    while (!bus.sda_oe && wait_n < 3*Q) begin tick(1); wait_n++; end
    chk("rst/oe_before", bus.sda_oe, 1);
    #10 rst_n = 1'b0;
    #1 chk("rst/oe_now", bus.sda_oe, 0);
    chk("rst/outs", {bus.rx_data, bus.rx_valid, bus.tx_req,
                     bus.addr_match, bus.rw, bus.busy}, 0);
    tick(2);
    bus.scl = 1'b1; tick(Q);
    rst_n = 1'b1; tick(Q);
    wdat[0] = 8'h5C; run_txn("post_rst", 8'h74, 1, 1);

    bus.enable = 1'b0;
    run_txn("en_off", 8'h74, 1, 1);
    bus.enable = 1'b1;
    begin
      int rxv0;
      rxv0 = n_rxv;
      i2c_start();
      wr_byte(8'h74, nak);
      chk("en_drop/addr_ack", nak, 0);
      bus.enable = 1'b0;
      wr_byte(8'h3C, nak);
      chk("en_drop/data_ack", nak, 0);
      chk("en_drop/rxv", n_rxv - rxv0, 1);
      chk("en_drop/rx_data", bus.rx_data, 8'h3C);
      i2c_stop();
      bus.enable = 1'b1;
    end

    for (int t = 0; t < 8; t++) begin
      logic [7:0] a;
      a = ($urandom_range(0, 2) != 0) ? {OWN, 1'($urandom)} : 8'($urandom);
      for (int k = 0; k < 4; k++) wdat[k] = 8'($urandom);
      bus.enable = ($urandom_range(0, 7) != 0);
      run_txn("rnd", a, $urandom_range(1, 3), 1);
    end

    chk("oe_while_scl_high", oe_bad, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
